// File: rtl/vc_tag_ctrl.sv
// vc_tag_ctrl: lookup/replacement controller for the 4-way fully-associative
// victim cache tag store. Tracks per-way valid bits and a 3-bit tree PLRU, serves
// LOOKUP/INSERT requests and drives the tag array write port on inserts.
// Optional build macro: VC_INVALIDATE_ON_HIT_EN (LOOKUP hit invalidates the way).
// tag_load/tag_way/tag_wdata and req_ready decode the current state; resp_* are registered.
module vc_tag_ctrl #(
    parameter int unsigned TAG_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [1:0]       resp_way,
    output logic             resp_evict,
    output logic [TAG_W-1:0] resp_evict_tag,
    input  logic [TAG_W-1:0] tag_out_a,
    input  logic [TAG_W-1:0] tag_out_b,
    input  logic [TAG_W-1:0] tag_out_c,
    input  logic [TAG_W-1:0] tag_out_d,
    output logic             tag_load,
    output logic [1:0]       tag_way,
    output logic [TAG_W-1:0] tag_wdata
);

    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned WAY_W    = 2;
    localparam int unsigned PLRU_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [PLRU_W-1:0]   plru_q, plru_d;

    logic                resp_valid_d, resp_hit_d, resp_evict_d;
    logic [WAY_W-1:0]    resp_way_d;
    logic [TAG_W-1:0]    resp_evict_tag_d;

    logic [TAG_W-1:0]    way_tag [NUM_WAYS];
    logic [NUM_WAYS-1:0] match;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;

    // PLRU victim: b0 picks the half, b1/b2 pick the way within it
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
        if (p[0]) return p[2] ? 2'd3 : 2'd2;
        else      return p[1] ? 2'd1 : 2'd0;
    endfunction

    // PLRU access update: point the tree away from the touched way
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                      input logic [WAY_W-1:0]  w);
        logic [PLRU_W-1:0] r;
        r    = p;
        r[0] = (w < 2'd2);
        if (w < 2'd2) r[1] = (w == 2'd0);
        else          r[2] = (w == 2'd2);
        return r;
    endfunction

    assign way_tag[0] = tag_out_a;
    assign way_tag[1] = tag_out_b;
    assign way_tag[2] = tag_out_c;
    assign way_tag[3] = tag_out_d;

    // Tag compare against valid ways, lowest matching way and fill victim
    always_comb begin
        match   = '0;
        hit_way = '0;
        victim  = plru_victim(plru_q);
        for (int i = 0; i < int'(NUM_WAYS); i++) begin
            match[i] = valid_q[i] && (way_tag[i] == tag_q);
        end
        for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
            if (match[i]) hit_way = WAY_W'(i);
        end
        for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = WAY_W'(i);
        end
    end

    assign hit = |match;

    // Next-state, datapath updates and array write strobe
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        tag_d            = tag_q;
        valid_d          = valid_q;
        plru_d           = plru_q;
        resp_valid_d     = resp_valid;
        resp_hit_d       = resp_hit;
        resp_way_d       = resp_way;
        resp_evict_d     = resp_evict;
        resp_evict_tag_d = resp_evict_tag;
        req_ready        = 1'b0;
        tag_load         = 1'b0;
        tag_way          = '0;
        tag_wdata        = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    tag_d   = req_tag;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                state_d          = S_RESP;
                resp_valid_d     = 1'b1;
                resp_hit_d       = hit;
                resp_way_d       = hit ? hit_way : '0;
                resp_evict_d     = 1'b0;
                resp_evict_tag_d = '0;
                if (!op_q) begin
                    if (hit) begin
`ifdef VC_INVALIDATE_ON_HIT_EN
                        valid_d[hit_way] = 1'b0;
`else
                        plru_d = plru_touch(plru_q, hit_way);
`endif
                    end
                end else if (hit) begin
                    plru_d = plru_touch(plru_q, hit_way);
                end else begin
                    tag_load         = 1'b1;
                    tag_way          = victim;
                    tag_wdata        = tag_q;
                    resp_way_d       = victim;
                    resp_evict_d     = valid_q[victim];
                    resp_evict_tag_d = way_tag[victim];
                    valid_d[victim]  = 1'b1;
                    plru_d           = plru_touch(plru_q, victim);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= 1'b0;
            tag_q          <= '0;
            valid_q        <= '0;
            plru_q         <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            tag_q          <= tag_d;
            valid_q        <= valid_d;
            plru_q         <= plru_d;
            resp_valid     <= resp_valid_d;
            resp_hit       <= resp_hit_d;
            resp_way       <= resp_way_d;
            resp_evict     <= resp_evict_d;
            resp_evict_tag <= resp_evict_tag_d;
        end
    end

endmodule

// File: tb/tb_vc_tag_ctrl.sv
// Bench for vc_tag_ctrl: directed spec sequence with literal expectations, then
// randomized traffic checked every cycle against a transaction-level cache model.
// Honours VC_INVALIDATE_ON_HIT_EN the same way the design does.
module tb_vc_tag_ctrl;

    localparam int unsigned TAG_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid = 1'b0, req_op = 1'b0, resp_ready = 1'b1;
    logic [TAG_W-1:0] req_tag = '0;
    logic             req_ready, resp_valid, resp_hit, resp_evict, tag_load;
    logic [1:0]       resp_way, tag_way;
    logic [TAG_W-1:0] resp_evict_tag, tag_wdata;
    logic [TAG_W-1:0] arr [4];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vc_tag_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .tag_out_a(arr[0]), .tag_out_b(arr[1]), .tag_out_c(arr[2]), .tag_out_d(arr[3]),
        .tag_load(tag_load), .tag_way(tag_way), .tag_wdata(tag_wdata)
    );

    // Tag array stand-in: unreset storage written by the controller
    always @(posedge clk) if (tag_load) arr[tag_way] <= tag_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               phase = 0;           // 0 waiting for request, 1 compare cycle, 2 responding
    logic [3:0]       mvalid = '0;
    logic [2:0]       mplru  = '0;         // bit0 root, bit1 A/B, bit2 C/D
    logic [TAG_W-1:0] mtag [4];
    logic             e_load = 0, e_hit = 0, e_evict = 0, e_way_chk = 0;
    logic [1:0]       e_way = '0;
    logic [TAG_W-1:0] e_etag = '0, e_wtag = '0;

    function automatic logic [2:0] touch(input logic [2:0] p, input int w);
        logic [2:0] r = p;
        r[0] = (w < 2);
        if (w < 2) r[1] = (w == 0); else r[2] = (w == 2);
        return r;
    endfunction

    function automatic int tree_victim(input logic [2:0] p);
        return p[0] ? (2 + int'(p[2])) : int'(p[1]);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int h, w, vic;
        logic [3:0] v;
        logic [2:0] p;
        if (!rst_n) begin
            phase  <= 0;
            mvalid <= '0;
            mplru  <= '0;
            e_load <= 1'b0;
        end else begin
            case (phase)
                0: if (req_valid) begin
                    h = 0; w = 0; v = mvalid; p = mplru;
                    for (int i = 3; i >= 0; i--)
                        if (mvalid[i] && mtag[i] == req_tag) begin h = 1; w = i; end
                    e_load <= 1'b0; e_evict <= 1'b0; e_way_chk <= (h != 0);
                    e_hit <= (h != 0); e_way <= 2'(w);
                    if (!req_op) begin
                        if (h != 0) begin
`ifdef VC_INVALIDATE_ON_HIT_EN
                            v[w] = 1'b0;
`else
                            p = touch(p, w);
`endif
                        end
                    end else if (h != 0) begin
                        p = touch(p, w);
                    end else begin
                        vic = -1;
                        for (int i = 3; i >= 0; i--) if (!mvalid[i]) vic = i;
                        if (vic < 0) vic = tree_victim(mplru);
                        e_load    <= 1'b1;
                        e_wtag    <= req_tag;
                        e_evict   <= mvalid[vic];
                        e_etag    <= mtag[vic];
                        e_way     <= 2'(vic);
                        e_way_chk <= 1'b1;
                        mtag[vic] <= req_tag;
                        v[vic]    = 1'b1;
                        p         = touch(p, vic);
                    end
                    mvalid <= v;
                    mplru  <= p;
                    phase  <= 1;
                end
                1: phase <= 2;
                default: if (resp_ready) phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(phase == 0));
        chk("tag_load", 32'(tag_load), 32'(phase == 1 && e_load));
        if (phase == 1 && e_load) begin
            chk("tag_way", 32'(tag_way), 32'(e_way));
            chk("tag_wdata", 32'(tag_wdata), 32'(e_wtag));
        end
        chk("resp_valid", 32'(resp_valid), 32'(phase == 2));
        if (phase == 2) begin
            chk("resp_hit", 32'(resp_hit), 32'(e_hit));
            chk("resp_evict", 32'(resp_evict), 32'(e_evict));
            if (e_way_chk) chk("resp_way", 32'(resp_way), 32'(e_way));
            if (e_evict) chk("resp_evict_tag", 32'(resp_evict_tag), 32'(e_etag));
        end
    end

    // ---------------- directed helpers ----------------
    logic             r_hit, r_evict;
    logic [1:0]       r_way;
    logic [TAG_W-1:0] r_etag;
    int               r_loads;

    task automatic do_req(input logic op, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1; req_op = op; req_tag = tag; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_loads = 0;
        for (int i = 0; i < 10 && !resp_valid; i++) begin
            r_loads += int'(tag_load);
            @(posedge clk); #1;
        end
        chk("resp_timeout", 32'(resp_valid), 32'd1);
        r_hit = resp_hit; r_way = resp_way; r_evict = resp_evict; r_etag = resp_evict_tag;
        @(posedge clk); #1;
    endtask

    task automatic expect_resp(input string nm, input logic hit, input logic [1:0] way,
                               input logic evict, input int loads);
        chk({nm, "_hit"}, 32'(r_hit), 32'(hit));
        chk({nm, "_evict"}, 32'(r_evict), 32'(evict));
        chk({nm, "_loads"}, 32'(r_loads), 32'(loads));
        if (hit || loads != 0) chk({nm, "_way"}, 32'(r_way), 32'(way));
    endtask

    logic [TAG_W-1:0] snap [4];

    initial begin
        arr[0] = 11'h123;                 // matching garbage in an invalid way
        arr[1] = 11'h400 | 11'($urandom_range(0, 255));
        arr[2] = 11'h400 | 11'($urandom_range(0, 255));
        arr[3] = 11'h010;                 // stale copy of a later insert tag
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_tag_load", 32'(tag_load), 32'd0);
        chk("rst_resp_way", 32'(resp_way), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 11'h123);
        expect_resp("lk123", 1'b0, 2'd0, 1'b0, 0);

        do_req(1'b1, 11'h010); expect_resp("ins010", 1'b0, 2'd0, 1'b0, 1);
        do_req(1'b1, 11'h020); expect_resp("ins020", 1'b0, 2'd1, 1'b0, 1);
        do_req(1'b1, 11'h030); expect_resp("ins030", 1'b0, 2'd2, 1'b0, 1);
        do_req(1'b1, 11'h040); expect_resp("ins040", 1'b0, 2'd3, 1'b0, 1);

        do_req(1'b0, 11'h010); expect_resp("lk010", 1'b1, 2'd0, 1'b0, 0);
`ifdef VC_INVALIDATE_ON_HIT_EN
        do_req(1'b0, 11'h010); expect_resp("lk010_again", 1'b0, 2'd0, 1'b0, 0);
        do_req(1'b1, 11'h050); expect_resp("ins050", 1'b0, 2'd0, 1'b0, 1);
`else
        do_req(1'b1, 11'h050); expect_resp("ins050", 1'b0, 2'd2, 1'b1, 1);
        chk("ins050_etag", 32'(r_etag), 32'h030);
`endif
        do_req(1'b1, 11'h020); expect_resp("ins020_dup", 1'b1, 2'd1, 1'b0, 0);

        // response held off for 5 cycles
        req_valid = 1'b1; req_op = 1'b0; req_tag = 11'h020; resp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_hit", 32'(resp_hit), 32'd1);
            chk("hold_way", 32'(resp_way), 32'd1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", 32'(req_ready), 32'd1);
        chk("release_valid", 32'(resp_valid), 32'd0);

        // reset during the compare cycle of a filling insert
        for (int i = 0; i < 4; i++) snap[i] = arr[i];
        req_valid = 1'b1; req_op = 1'b1; req_tag = 11'h066;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("cmp_tag_load", 32'(tag_load), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_kills_load", 32'(tag_load), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) chk("no_write_after_rst", 32'(arr[i]), 32'(snap[i]));
        @(posedge clk); #1;
        do_req(1'b0, 11'h020); expect_resp("lk_after_rst", 1'b0, 2'd0, 1'b0, 0);

        // randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_op     = 1'($urandom_range(0, 1));
            req_tag    = 11'(16 * $urandom_range(1, 7));
            resp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
